// File: rtl/rob_flush_param.sv
// ---------------------------------------------------------------------------
// rob_flush_param -- parametrised in-order reorder buffer with misprediction
// flush, store-commit backpressure and two combinational operand-query ports.
//
// Parameters : DEPTH (entries, power of two 4..64), IDX_W (log2(DEPTH), tag width)
// Optional   : define ROB_PERF_COUNTERS_EN to add perf_commits / perf_flushes.
//
// Ports
//   clk_in, rst_in (async, active-high), rdy_in (global enable)
//   alloc_*          : dispatch side; alloc_ready/alloc_tag are combinational
//   alu_* / load_*   : writeback buses addressed by RoB tag
//   q1_*, q2_*       : combinational operand lookup by tag
//   store_commit_*   : head-store handshake to the store buffer
//   reg_commit_*     : registered register-file writeback pulse
//   flush_out/pc     : registered misprediction redirect pulse
//   count            : occupancy (0..DEPTH)
// ---------------------------------------------------------------------------
module rob_flush_param #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  logic [5:0]       alloc_type,
    input  logic [4:0]       alloc_rd,
    input  logic [31:0]      alloc_pc,
    input  logic             alloc_pred,
    output logic [IDX_W-1:0] alloc_tag,
    input  logic             alu_done,
    input  logic [IDX_W-1:0] alu_rob_pos,
    input  logic [31:0]      alu_res,
    input  logic             alu_jump,
    input  logic [31:0]      alu_jump_addr,
    input  logic             load_done,
    input  logic [IDX_W-1:0] load_rob_pos,
    input  logic [31:0]      load_res,
    input  logic [IDX_W-1:0] q1_tag,
    input  logic [IDX_W-1:0] q2_tag,
    output logic             q1_ready,
    output logic             q2_ready,
    output logic [31:0]      q1_val,
    output logic [31:0]      q2_val,
    input  logic             store_commit_ready,
    output logic             store_commit_valid,
    output logic [IDX_W-1:0] store_commit_tag,
    output logic             reg_commit,
    output logic [4:0]       reg_commit_rd,
    output logic [31:0]      reg_commit_val,
    output logic [IDX_W-1:0] reg_commit_tag,
    output logic             flush_out,
    output logic [31:0]      flush_pc,
    output logic [IDX_W:0]   count
`ifdef ROB_PERF_COUNTERS_EN
    ,
    output logic [31:0]      perf_commits,
    output logic [31:0]      perf_flushes
`endif
);

    localparam logic [IDX_W:0]   DEPTH_C = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W:0]   CNT_ONE = (IDX_W+1)'(1);

    // Control state (reset)
    logic [IDX_W-1:0] head, tail;
    logic [IDX_W:0]   cnt;
    logic [DEPTH-1:0] busy, ready_q;

    // Entry payload (not reset; qualified by busy/ready)
    logic [5:0]       type_q  [DEPTH];
    logic [4:0]       rd_q    [DEPTH];
    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      val_q   [DEPTH];
    logic [31:0]      jaddr_q [DEPTH];
    logic [DEPTH-1:0] pred_q, jump_q;

    logic [5:0] h_type;
    logic       h_is_store, h_is_br, h_is_jalr, h_mispred;
    logic       commit, flush, do_alloc, alu_wb, load_wb;

    assign h_type     = type_q[head];
    assign h_is_store = (h_type >= 6'd15) && (h_type <= 6'd17);
    assign h_is_br    = (h_type >= 6'd4) && (h_type <= 6'd9);
    assign h_is_jalr  = (h_type == 6'd3);
    assign h_mispred  = (h_is_br || h_is_jalr) && (jump_q[head] != pred_q[head]);

    // Commit looks only at registered ready; a same-cycle writeback is not bypassed.
    assign commit   = rdy_in && (cnt != '0) && ready_q[head] &&
                      (!h_is_store || store_commit_ready);
    assign flush    = commit && h_mispred;
    assign do_alloc = rdy_in && alloc_valid && alloc_ready;
    assign alu_wb   = rdy_in && alu_done  && busy[alu_rob_pos];
    assign load_wb  = rdy_in && load_done && busy[load_rob_pos];

    assign alloc_ready = (cnt < DEPTH_C);
    assign alloc_tag   = tail;
    assign count       = cnt;

    assign q1_ready = busy[q1_tag] & ready_q[q1_tag];
    assign q2_ready = busy[q2_tag] & ready_q[q2_tag];
    assign q1_val   = busy[q1_tag] ? val_q[q1_tag] : 32'd0;
    assign q2_val   = busy[q2_tag] ? val_q[q2_tag] : 32'd0;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head               <= '0;
            tail               <= '0;
            cnt                <= '0;
            busy               <= '0;
            ready_q            <= '0;
            store_commit_valid <= 1'b0;
            store_commit_tag   <= '0;
            reg_commit         <= 1'b0;
            reg_commit_rd      <= '0;
            reg_commit_val     <= '0;
            reg_commit_tag     <= '0;
            flush_out          <= 1'b0;
            flush_pc           <= '0;
        end else if (!rdy_in) begin
            store_commit_valid <= 1'b0;
            reg_commit         <= 1'b0;
            flush_out          <= 1'b0;
        end else begin
            store_commit_valid <= 1'b0;
            reg_commit         <= 1'b0;
            flush_out          <= 1'b0;

            if (commit) begin
                if (h_is_store) begin
                    store_commit_valid <= 1'b1;
                    store_commit_tag   <= head;
                end else if (!h_is_br) begin
                    reg_commit     <= 1'b1;
                    reg_commit_rd  <= rd_q[head];
                    reg_commit_val <= val_q[head];
                    reg_commit_tag <= head;
                end
            end

            if (flush) begin
                // Whole buffer squashed; same-cycle alloc/writeback discarded.
                head      <= '0;
                tail      <= '0;
                cnt       <= '0;
                busy      <= '0;
                ready_q   <= '0;
                flush_out <= 1'b1;
                flush_pc  <= jump_q[head] ? jaddr_q[head] : pc_q[head] + 32'd4;
            end else begin
                if (alu_wb)  ready_q[alu_rob_pos]  <= 1'b1;
                if (load_wb) ready_q[load_rob_pos] <= 1'b1;
                if (do_alloc) begin
                    busy[tail]    <= 1'b1;
                    ready_q[tail] <= 1'b0;
                    tail          <= tail + IDX_ONE;
                end
                // head != tail whenever commit and alloc coincide (0<cnt<DEPTH)
                if (commit) begin
                    busy[head]    <= 1'b0;
                    ready_q[head] <= 1'b0;
                    head          <= head + IDX_ONE;
                end
                case ({do_alloc, commit})
                    2'b10:   cnt <= cnt + CNT_ONE;
                    2'b01:   cnt <= cnt - CNT_ONE;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush) begin
            if (do_alloc) begin
                type_q[tail] <= alloc_type;
                rd_q[tail]   <= alloc_rd;
                pc_q[tail]   <= alloc_pc;
                pred_q[tail] <= alloc_pred;
            end
            if (alu_wb) begin
                val_q[alu_rob_pos]   <= alu_res;
                jump_q[alu_rob_pos]  <= alu_jump;
                jaddr_q[alu_rob_pos] <= alu_jump_addr;
            end
            // Placed after the ALU write so the load wins on a shared tag.
            if (load_wb) begin
                val_q[load_rob_pos]  <= load_res;
                jump_q[load_rob_pos] <= 1'b0;
            end
        end
    end

`ifdef ROB_PERF_COUNTERS_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_commits <= '0;
            perf_flushes <= '0;
        end else if (rdy_in) begin
            if (commit) perf_commits <= perf_commits + 32'd1;
            if (flush)  perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_flush_param.sv
module tb_rob_flush_param;

    localparam int DEPTH = 16;
    localparam int IDX_W = 4;

    logic             clk_in = 1'b0;
    logic             rst_in, rdy_in;
    logic             alloc_valid, alloc_ready, alloc_pred;
    logic [5:0]       alloc_type;
    logic [4:0]       alloc_rd;
    logic [31:0]      alloc_pc;
    logic [IDX_W-1:0] alloc_tag;
    logic             alu_done, alu_jump, load_done;
    logic [IDX_W-1:0] alu_rob_pos, load_rob_pos, q1_tag, q2_tag;
    logic [31:0]      alu_res, alu_jump_addr, load_res, q1_val, q2_val;
    logic             q1_ready, q2_ready;
    logic             store_commit_ready, store_commit_valid;
    logic [IDX_W-1:0] store_commit_tag, reg_commit_tag;
    logic             reg_commit, flush_out;
    logic [4:0]       reg_commit_rd;
    logic [31:0]      reg_commit_val, flush_pc;
    logic [IDX_W:0]   count;
`ifdef ROB_PERF_COUNTERS_EN
    logic [31:0]      perf_commits, perf_flushes;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    rob_flush_param #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_type(alloc_type), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
        .alloc_pred(alloc_pred), .alloc_tag(alloc_tag),
        .alu_done(alu_done), .alu_rob_pos(alu_rob_pos), .alu_res(alu_res),
        .alu_jump(alu_jump), .alu_jump_addr(alu_jump_addr),
        .load_done(load_done), .load_rob_pos(load_rob_pos), .load_res(load_res),
        .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_val(q1_val), .q2_val(q2_val),
        .store_commit_ready(store_commit_ready),
        .store_commit_valid(store_commit_valid), .store_commit_tag(store_commit_tag),
        .reg_commit(reg_commit), .reg_commit_rd(reg_commit_rd),
        .reg_commit_val(reg_commit_val), .reg_commit_tag(reg_commit_tag),
        .flush_out(flush_out), .flush_pc(flush_pc), .count(count)
`ifdef ROB_PERF_COUNTERS_EN
        , .perf_commits(perf_commits), .perf_flushes(perf_flushes)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        alloc_valid = 1'b0; alloc_type = 6'd18; alloc_rd = '0; alloc_pc = '0; alloc_pred = 1'b0;
        alu_done = 1'b0; alu_rob_pos = '0; alu_res = '0; alu_jump = 1'b0; alu_jump_addr = '0;
        load_done = 1'b0; load_rob_pos = '0; load_res = '0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        #3;
        rst_in = 1'b0;
        step();
    endtask

    task automatic alloc(input logic [5:0] t, input logic [4:0] rd, input logic [31:0] pc,
                         input logic pred);
        alloc_valid = 1'b1; alloc_type = t; alloc_rd = rd; alloc_pc = pc; alloc_pred = pred;
    endtask

    initial begin
        rdy_in = 1'b1; store_commit_ready = 1'b1; q1_tag = '0; q2_tag = '0;
        idle();
        rst_in = 1'b1;
        #2;
        // --- reset state
        check("rst_count", count, 0);
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_alloc_tag", alloc_tag, 0);
        check("rst_pulses", {reg_commit, store_commit_valid, flush_out}, 0);
        check("rst_flush_pc", flush_pc, 0);
        rst_in = 1'b0;
        step();

        // --- 1: fill all 16 entries
        for (int i = 0; i < DEPTH; i++) begin
            alloc(6'd18, 5'(i), 32'(i * 4), 1'b0);
            step();
        end
        check("full_count", count, 16);
        check("full_alloc_ready", alloc_ready, 0);
        check("full_alloc_tag", alloc_tag, 0);
        step();  // 17th request while full
        check("full17_count", count, 16);
        check("full17_alloc_tag", alloc_tag, 0);
        idle();
        do_reset();

        // --- 2: ALU writeback then commit
        check("t2_tag0", alloc_tag, 0);
        alloc(6'd18, 5'd5, 32'h40, 1'b0);
        step();
        idle();
        alu_done = 1'b1; alu_rob_pos = 4'd0; alu_res = 32'h1234;
        step();
        idle();
        q1_tag = 4'd0;
        #1;
        check("t2_q1_ready", q1_ready, 1);
        check("t2_q1_val", q1_val, 32'h1234);
        check("t2_no_commit_yet", reg_commit, 0);
        step();
        check("t2_reg_commit", reg_commit, 1);
        check("t2_rd", reg_commit_rd, 5);
        check("t2_val", reg_commit_val, 32'h1234);
        check("t2_tag", reg_commit_tag, 0);
        check("t2_q1_freed", {q1_ready, q1_val}, 0);
        step();
        check("t2_pulse_end", reg_commit, 0);
        check("t2_count", count, 0);

        // --- 3: store backpressure (SW lands at tag 1)
        alloc(6'd17, 5'd0, 32'h44, 1'b0);
        step();
        idle();
        alu_done = 1'b1; alu_rob_pos = 4'd1; alu_res = 32'hdead;
        store_commit_ready = 1'b0;
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_stall_valid", store_commit_valid, 0);
            check("t3_stall_count", count, 1);
        end
        store_commit_ready = 1'b1;
        step();
        check("t3_store_valid", store_commit_valid, 1);
        check("t3_store_tag", store_commit_tag, 1);
        check("t3_no_reg_commit", reg_commit, 0);
        check("t3_count", count, 0);
        step();
        check("t3_single_pulse", store_commit_valid, 0);

        // --- 4a: BEQ at tag 2, pred=0, taken to 0x80, four younger entries
        alloc(6'd4, 5'd0, 32'h100, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            alloc(6'd18, 5'(i + 1), 32'h104 + 32'(i * 4), 1'b0);
            step();
        end
        idle();
        alu_done = 1'b1; alu_rob_pos = 4'd2; alu_jump = 1'b1; alu_jump_addr = 32'h80;
        step();
        idle();
        check("t4_pre_count", count, 5);
        alloc(6'd18, 5'd9, 32'h200, 1'b0);  // discarded by the flush
        step();
        idle();
        check("t4_flush_out", flush_out, 1);
        check("t4_flush_pc", flush_pc, 32'h80);
        check("t4_flush_no_reg", reg_commit, 0);
        check("t4_count", count, 0);
        check("t4_alloc_tag", alloc_tag, 0);
        step();
        check("t4_flush_end", flush_out, 0);

        // --- 4b: BNE pred=1, resolved not taken
        alloc(6'd5, 5'd0, 32'h100, 1'b1);
        step();
        idle();
        alu_done = 1'b1; alu_rob_pos = 4'd0; alu_jump = 1'b0; alu_jump_addr = 32'h999;
        step();
        idle();
        step();
        check("t4b_flush_out", flush_out, 1);
        check("t4b_flush_pc", flush_pc, 32'h104);

        // --- correctly predicted branch: no flush, no reg commit
        alloc(6'd4, 5'd0, 32'h300, 1'b1);
        step();
        idle();
        alu_done = 1'b1; alu_rob_pos = 4'd0; alu_jump = 1'b1; alu_jump_addr = 32'h500;
        step();
        idle();
        step();
        check("t4c_no_flush", {flush_out, reg_commit}, 0);
        check("t4c_count", count, 0);

        // --- rdy_in low freezes state
        rdy_in = 1'b0;
        alloc(6'd18, 5'd1, 32'h0, 1'b0);
        step();
        check("frz_count", count, 0);
        check("frz_tag", alloc_tag, 1);
        rdy_in = 1'b1;
        idle();

        // --- 5: steady alloc+commit across the tail wrap, then async reset
        do_reset();
        alloc(6'd18, 5'd0, 32'h0, 1'b0);
        step();
        for (int i = 1; i <= 20; i++) begin
            check("t5_alloc_tag", alloc_tag, 64'(i % 16));
            alloc(6'd18, 5'(i), 32'(i * 4), 1'b0);
            alu_done = 1'b1; alu_rob_pos = 4'((i - 1) % 16); alu_res = 32'h1000 + 32'(i - 1);
            step();
            if (i >= 2) begin
                check("t5_commit", reg_commit, 1);
                check("t5_tag", reg_commit_tag, 64'((i - 2) % 16));
                check("t5_val", reg_commit_val, 64'(32'h1000 + i - 2));
                check("t5_rd", reg_commit_rd, 64'(i - 2));
                check("t5_count", count, 2);
            end
        end
        #2;
        rst_in = 1'b1;
        #1;
        check("t5_rst_pulses", {reg_commit, store_commit_valid, flush_out}, 0);
        check("t5_rst_outs", {reg_commit_val, reg_commit_tag, reg_commit_rd}, 0);
        check("t5_rst_count", count, 0);
        check("t5_rst_ready", alloc_ready, 1);
        idle();
        rst_in = 1'b0;
        step();

        // --- 6: ALU and load on the same tag; load wins. Load to a free tag ignored.
        alloc(6'd18, 5'd7, 32'h0, 1'b0);
        step();
        idle();
        alu_done = 1'b1; alu_rob_pos = 4'd0; alu_res = 32'h1111;
        load_done = 1'b1; load_rob_pos = 4'd0; load_res = 32'h2222;
        step();
        load_rob_pos = 4'd5; load_res = 32'h5555; alu_done = 1'b0;
        q2_tag = 4'd5;
        step();
        idle();
        check("t6_commit", reg_commit, 1);
        check("t6_load_wins", reg_commit_val, 32'h2222);
        check("t6_rd", reg_commit_rd, 7);
        check("t6_free_q2", {q2_ready, q2_val}, 0);
        check("t6_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rob_flush_param.md
Name: rob_flush_param

Overview:
- Parametrised in-order reorder buffer for the out-of-order core; successor to the fixed 16-entry RoB.
- Sits between decoder/dispatch, the ALU/load writeback buses, the register file and the store buffer.
- Adds over the previous generation:
  - configurable depth
  - count-based full/empty, so all DEPTH slots are usable
  - store-commit backpressure
  - branch/JALR misprediction detection with full flush and redirect
  - two combinational operand-query ports

Parameters:
DEPTH, 16, number of entries; power of two, 4..64
IDX_W, 4, log2(DEPTH); tag width

Ports:
clk_in  input  1  clock
rst_in  input  1  reset, asynchronous, active-high
rdy_in  input  1  global enable; low freezes all state
alloc_valid  input  1  dispatch request
alloc_ready  output  1  comb: count<DEPTH
alloc_type  input  6  instruction type code (LUI=0 … AND=36; BEQ..BGEU=4..9, JALR=3, SB..SW=15..17)
alloc_rd  input  5  destination register
alloc_pc  input  32  instruction PC
alloc_pred  input  1  predicted taken
alloc_tag  output  IDX_W  comb: current tail index
alu_done  input  1  ALU writeback valid
alu_rob_pos  input  IDX_W  ALU writeback tag
alu_res  input  32  ALU result
alu_jump  input  1  resolved taken
alu_jump_addr  input  32  resolved target
load_done  input  1  load writeback valid
load_rob_pos  input  IDX_W  load writeback tag
load_res  input  32  load data
q1_tag, q2_tag  input  IDX_W  operand query tags
q1_ready, q2_ready  output  1  comb: entry busy and ready
q1_val, q2_val  output  32  comb: entry value
store_commit_ready  input  1  store buffer can accept
store_commit_valid  output  1  registered pulse: head store committed
store_commit_tag  output  IDX_W  tag of committed store
reg_commit  output  1  registered pulse: register writeback
reg_commit_rd  output  5  destination
reg_commit_val  output  32  value
reg_commit_tag  output  IDX_W  committing tag (for rename clear)
flush_out  output  1  registered pulse: mispredict flush
flush_pc  output  32  redirect PC
count  output  IDX_W+1  occupancy

Behaviour:
- Reset, asynchronous:
  - head=tail=count=0; all busy/ready bits clear.
  - All registered outputs 0. alloc_ready=1.
- rdy_in low: no state changes; registered pulse outputs forced 0 on the next edge.
- Allocation:
  - Occurs when alloc_valid && alloc_ready.
  - Entry[tail] gets busy=1, ready=0, type, rd, pc, pred.
  - tail wraps modulo DEPTH.
- Writeback:
  - A done channel sets val, jump, jump_addr and ready=1 on its tag. Load sets jump=0.
  - Writeback to a non-busy entry is ignored.
  - ALU and load on the same tag in the same cycle: load wins.
- Commit: at most one per cycle, only when count>0 and ready[head] (registered state; same-cycle writeback is not bypassed).
  - Store (15..17): commits only if store_commit_ready=1. Next cycle store_commit_valid=1 and store_commit_tag=head. No reg_commit.
  - Branch (4..9): no reg_commit.
  - JALR: reg_commit with val.
  - All other types: reg_commit=1, rd, val, tag=head. Pulses are issued even for rd=0; the regfile ignores x0.
  - On commit, head advances and busy/ready of the old head are cleared.
- Mispredict:
  - Applies to a branch or JALR at commit when jump != pred.
  - Next cycle: flush_out=1, flush_pc = jump ? jump_addr : pc+4 (32-bit wrap).
  - In the commit cycle itself: head=tail=count=0, all busy cleared, and any same-cycle allocation and writebacks are discarded. Upstream squashes on flush_out.
- count:
  - +1 on allocation, −1 on commit, unchanged when both occur.
  - Full (count=DEPTH) blocks allocation even if a commit occurs the same cycle.
- Query outputs: q*_ready=0 and q*_val=0 for a non-busy entry.
- Reset asserted mid-operation: immediate clear; in-flight pulses are dropped.

Optional Feature:
- Macro: ROB_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs perf_commits[31:0] and perf_flushes[31:0].
  - Free-running wrap-around counters, incremented per commit and per mispredict flush.
  - Reset to 0; frozen while rdy_in low.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then allocate 16 ADDI with DEPTH=16 → alloc_ready=0 and count=16; the 17th request is ignored and alloc_tag stays 0.
2. Allocate ADDI rd=5 at tag 0; alu_done tag 0 res=0x1234 → reg_commit=1, rd=5, val=0x1234, tag=0 two cycles after writeback; q1 on tag 0 reads ready=1 before commit.
3. Head SW ready with store_commit_ready=0 for 3 cycles, then 1 → store_commit_valid exactly once, tag=head, on the cycle after ready rises; head stalls meanwhile.
4. BEQ pc=0x100, pred=0, alu_jump=1, addr=0x80, with 4 younger entries → flush_out=1, flush_pc=0x80, then count=0 and alloc_tag=0. With pred=1 and jump=0 → flush_pc=0x104.
5. Fill to wrap (tail 15→0) with simultaneous alloc+commit each cycle → count constant; commits emerge in allocation order. Assert rst_in mid-stream → all outputs 0 asynchronously.
6. ALU and load writeback on the same tag in one cycle → committed val equals load_res.
